// File: rtl/if_id_skid_stage_if.sv
// ============================================================================
// Module   : if_id_skid_stage_if
// Brief    : IF->ID valid/ready bus (IF-side inputs and ID-side outputs).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface if_id_skid_stage_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;

  // master: IF producer and ID consumer surrounding the stage
  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst
  );

  // slave: the pipeline stage itself
  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst
  );
endinterface

`default_nettype wire

// File: rtl/if_id_skid_stage.sv
// ============================================================================
// Module   : if_id_skid_stage
// Brief    : IF/ID stage with two-entry skid buffer, flush and halt drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_id_skid_stage #(
  parameter int                 PC_W         = 32,
  parameter int                 INST_W       = 32,
  parameter logic [INST_W-1:0]  NOP_INST     = 32'h00000013,
  parameter logic [INST_W-1:0]  HALT_INST    = 32'hFFFFFFFF,
  parameter int                 DRAIN_CYCLES = 4
) (
  input  wire                   clk,
  input  wire                   rst,
  input  wire                   flush,
  if_id_skid_stage_if.slave     bus,
  output logic                  halt_seen,
  output logic                  o_finish
);

  localparam logic [3:0] c_DRAIN = 4'(DRAIN_CYCLES);

  logic              r_main_valid;
  logic [PC_W-1:0]   r_main_pc;
  logic [INST_W-1:0] r_main_inst;
  logic              r_skid_valid;
  logic [PC_W-1:0]   r_skid_pc;
  logic [INST_W-1:0] r_skid_inst;
  logic              r_halt_seen;
  logic [3:0]        r_drain_cnt;
  logic              r_finish;

  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;
  logic w_halt_fire;

  assign w_in_ready  = ~r_skid_valid & ~r_halt_seen;
  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = r_main_valid & bus.out_ready;
  assign w_halt_fire = w_out_fire & (r_main_inst == HALT_INST);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_main_valid;
  assign bus.out_pc    = r_main_pc;
  assign bus.out_inst  = r_main_inst;
  assign halt_seen     = r_halt_seen;
  assign o_finish      = r_finish;

  // Main register keeps NOP/0 whenever it is empty so out_* need no muxing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_pc    <= '0;
      r_main_inst  <= NOP_INST;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_inst  <= NOP_INST;
    end else if (flush || w_halt_fire) begin
      r_main_valid <= 1'b0;
      r_main_pc    <= '0;
      r_main_inst  <= NOP_INST;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_out_fire) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_pc    <= r_skid_pc;
        r_main_inst  <= r_skid_inst;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_main_valid <= 1'b1;
        r_main_pc    <= bus.in_pc;
        r_main_inst  <= bus.in_inst;
      end else begin
        r_main_valid <= 1'b0;
        r_main_pc    <= '0;
        r_main_inst  <= NOP_INST;
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_pc    <= bus.in_pc;
      r_skid_inst  <= bus.in_inst;
    end
  end

  // Drain counter starts once the halt has left the stage and saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halt_seen <= 1'b0;
      r_drain_cnt <= 4'd0;
      r_finish    <= 1'b0;
    end else if (flush) begin
      r_halt_seen <= 1'b0;
      r_drain_cnt <= 4'd0;
      r_finish    <= 1'b0;
    end else begin
      if (w_halt_fire) begin
        r_halt_seen <= 1'b1;
      end
      if (r_halt_seen && (r_drain_cnt < c_DRAIN)) begin
        r_drain_cnt <= r_drain_cnt + 4'd1;
        if (r_drain_cnt + 4'd1 == c_DRAIN) begin
          r_finish <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
